// File: rtl/io_responder_pkg.sv
// Shared register map and bit positions for the IO responder.
// Pulled in by the top with import io_pkg::*.
package io_pkg;

    localparam logic [7:0] IO_LED      = 8'h00;
    localparam logic [7:0] IO_IN_STAT  = 8'h04;
    localparam logic [7:0] IO_IN_DATA  = 8'h08;
    localparam logic [7:0] IO_OUT_STAT = 8'h0C;
    localparam logic [7:0] IO_OUT_DATA = 8'h10;
    localparam logic [7:0] IO_CTRL     = 8'h14;
    localparam logic [7:0] IO_IRQ_MASK = 8'h18;

    localparam int CTRL_CLR_OVF_BIT  = 0;
    localparam int CTRL_CLR_DROP_BIT = 1;
    localparam int CTRL_FLUSH_BIT    = 2;

    localparam int IRQ_FIFO_NE_BIT  = 0;
    localparam int IRQ_OUT_FREE_BIT = 1;

    // Status layout: {16'b0, count, 6'b0, ovf, not_empty}
    function automatic logic [31:0] in_stat_word(input logic [7:0] cnt,
                                                 input logic       ovf,
                                                 input logic       not_empty);
        return {16'h0000, cnt, 6'b000000, ovf, not_empty};
    endfunction

    function automatic logic [31:0] out_stat_word(input logic drop,
                                                  input logic slot_free);
        return {30'h0000_0000, drop, slot_free};
    endfunction

endpackage

// File: rtl/io_responder_if.sv
// Core-side IO bus: the core drives address/strobes/store data and
// samples the combinational load data returned by the responder.
interface io_responder_if;
    logic [7:0]  io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic        io_rd;
    logic [31:0] io_din;

    modport master (output io_addr, output io_dout, output io_we, output io_rd, input io_din);
    modport slave  (input io_addr, input io_dout, input io_we, input io_rd, output io_din);
endinterface

// File: rtl/io_responder_in_fifo.sv
// Input word FIFO for the IO responder: push/pop/flush, head word, count.
// Head reads as zero when empty so stale entries never leak to the core.
module io_in_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          push,
    input  logic                          pop,
    input  logic [31:0]                   push_data,
    output logic [31:0]                   head,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [31:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          full_s;
    logic          empty_s;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_s    = (count_r == (AW+1)'(FIFO_DEPTH));
    assign empty_s   = (count_r == {(AW+1){1'b0}});
    assign do_pop_s  = pop && !empty_s;
    // A pop in the same cycle frees the slot a full FIFO needs for the push
    assign do_push_s = push && (!full_s || do_pop_s);

    // Storage, pointers and occupancy; flush overrides any push/pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head word presented to the load mux
    always_comb begin
        head = 32'h0000_0000;
        if (empty_s) begin
            head = 32'h0000_0000;
        end else begin
            head = mem_r[rd_ptr_r];
        end
    end

    assign count = count_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/io_responder.sv
// Memory-mapped IO responder: LED register, input FIFO, output valid/ready slot.
// Optional IRQ output and mask register enabled by defining IO_RESPONDER_IRQ_EN.
module io_responder
    import io_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LED_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    io_responder_if.slave     bus,
    input  logic [31:0]       in_data,
    input  logic              in_vld,
    output logic [31:0]       out_data,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [LED_W-1:0]  led
`ifdef IO_RESPONDER_IRQ_EN
    ,
    output logic              irq
`endif
);
    logic [LED_W-1:0]             led_r;
    logic [31:0]                  out_data_r;
    logic                         out_vld_r;
    logic                         ovf_r;
    logic                         drop_r;

    logic                         wr_led_s;
    logic                         wr_out_s;
    logic                         wr_ctrl_s;
    logic                         rd_in_data_s;
    logic                         pop_s;
    logic                         flush_s;
    logic                         ovf_set_s;
    logic                         drop_set_s;
    logic                         slot_accept_s;
    logic [31:0]                  io_din_s;

    logic [31:0]                  fifo_head_s;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count_s;
    logic                         fifo_full_s;
    logic                         fifo_empty_s;
    logic [7:0]                   count8_s;

`ifdef IO_RESPONDER_IRQ_EN
    logic                         wr_mask_s;
    logic [1:0]                   irq_mask_r;
    logic                         irq_r;
`endif

    // Store decode; read-only and unmapped addresses decode to nothing
    always_comb begin
        wr_led_s  = 1'b0;
        wr_out_s  = 1'b0;
        wr_ctrl_s = 1'b0;
`ifdef IO_RESPONDER_IRQ_EN
        wr_mask_s = 1'b0;
`endif
        if (bus.io_we) begin
            case (bus.io_addr)
                IO_LED:      wr_led_s  = 1'b1;
                IO_OUT_DATA: wr_out_s  = 1'b1;
                IO_CTRL:     wr_ctrl_s = 1'b1;
`ifdef IO_RESPONDER_IRQ_EN
                IO_IRQ_MASK: wr_mask_s = 1'b1;
`endif
                default:     wr_led_s  = 1'b0;
            endcase
        end else begin
            wr_led_s = 1'b0;
        end
    end

    assign rd_in_data_s  = bus.io_rd && (bus.io_addr == IO_IN_DATA);
    assign pop_s         = rd_in_data_s && !fifo_empty_s;
    assign flush_s       = wr_ctrl_s && bus.io_dout[CTRL_FLUSH_BIT];
    assign ovf_set_s     = in_vld && fifo_full_s && !pop_s;
    assign slot_accept_s = !out_vld_r || out_rdy;
    assign drop_set_s    = wr_out_s && !slot_accept_s;
    assign count8_s      = 8'(fifo_count_s);

    io_in_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_in_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_s),
        .push      (in_vld),
        .pop       (pop_s),
        .push_data (in_data),
        .head      (fifo_head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Combinational load mux back to the core
    always_comb begin
        io_din_s = 32'h0000_0000;
        if (bus.io_rd) begin
            case (bus.io_addr)
                IO_LED:      io_din_s = 32'(led_r);
                IO_IN_STAT:  io_din_s = in_stat_word(count8_s, ovf_r, !fifo_empty_s);
                IO_IN_DATA:  io_din_s = fifo_head_s;
                IO_OUT_STAT: io_din_s = out_stat_word(drop_r, !out_vld_r);
`ifdef IO_RESPONDER_IRQ_EN
                IO_IRQ_MASK: io_din_s = {30'h0000_0000, irq_mask_r};
`endif
                default:     io_din_s = 32'h0000_0000;
            endcase
        end else begin
            io_din_s = 32'h0000_0000;
        end
    end

    assign bus.io_din = io_din_s;

    // LED register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_r <= {LED_W{1'b0}};
        end else if (wr_led_s) begin
            led_r <= bus.io_dout[LED_W-1:0];
        end else begin
            led_r <= led_r;
        end
    end

    // Output slot: a store only lands when the slot is free or draining this cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_r <= 32'h0000_0000;
            out_vld_r  <= 1'b0;
        end else if (wr_out_s && slot_accept_s) begin
            out_data_r <= bus.io_dout;
            out_vld_r  <= 1'b1;
        end else if (out_vld_r && out_rdy) begin
            out_vld_r  <= 1'b0;
        end else begin
            out_vld_r  <= out_vld_r;
        end
    end

    // Sticky overflow/drop flags; a same-cycle set beats a CTRL clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_r  <= 1'b0;
            drop_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (wr_ctrl_s && bus.io_dout[CTRL_CLR_OVF_BIT]) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
            if (drop_set_s) begin
                drop_r <= 1'b1;
            end else if (wr_ctrl_s && bus.io_dout[CTRL_CLR_DROP_BIT]) begin
                drop_r <= 1'b0;
            end else begin
                drop_r <= drop_r;
            end
        end
    end

`ifdef IO_RESPONDER_IRQ_EN
    // Interrupt mask and registered interrupt, sampled from current state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_mask_r <= 2'b00;
            irq_r      <= 1'b0;
        end else begin
            if (wr_mask_s) begin
                irq_mask_r <= bus.io_dout[1:0];
            end else begin
                irq_mask_r <= irq_mask_r;
            end
            irq_r <= (irq_mask_r[IRQ_FIFO_NE_BIT]  && !fifo_empty_s) ||
                     (irq_mask_r[IRQ_OUT_FREE_BIT] && !out_vld_r);
        end
    end

    assign irq = irq_r;
`endif

    assign led      = led_r;
    assign out_data = out_data_r;
    assign out_vld  = out_vld_r;

endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: vector table replayed through a scoreboard queue,
// plus hand-written reset and interrupt sequences.
module tb_io_responder;
    import io_pkg::*;

    localparam int FIFO_DEPTH = 8;
    localparam int LED_W      = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_vld;
    logic [31:0] out_data;
    logic        out_vld;
    logic        out_rdy;
    logic [15:0] led;
`ifdef IO_RESPONDER_IRQ_EN
    logic        irq;
`endif

    io_responder_if bus ();

    io_responder #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .LED_W      (LED_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .in_data  (in_data),
        .in_vld   (in_vld),
        .out_data (out_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .led      (led)
`ifdef IO_RESPONDER_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic        we;
        logic        rd;
        logic [31:0] wdata;
        logic        in_vld;
        logic [31:0] in_data;
        logic        out_rdy;
        logic [31:0] exp_din;
        logic        exp_vld;
        logic [31:0] exp_odata;
        logic [15:0] exp_led;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] a, input logic we, input logic rd, input logic [31:0] wd,
                       input logic iv, input logic [31:0] id, input logic rdy,
                       input logic [31:0] din, input logic vld, input logic [31:0] od,
                       input logic [15:0] l);
        vec_t v;
        v.addr = a; v.we = we; v.rd = rd; v.wdata = wd;
        v.in_vld = iv; v.in_data = id; v.out_rdy = rdy;
        v.exp_din = din; v.exp_vld = vld; v.exp_odata = od; v.exp_led = l;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [7:0] a, input logic we, input logic rd, input logic [31:0] wd,
                         input logic iv, input logic [31:0] id, input logic rdy);
        bus.io_addr = a; bus.io_we = we; bus.io_rd = rd; bus.io_dout = wd;
        in_vld = iv; in_data = id; out_rdy = rdy;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one vector, check load data before the edge and registered outputs after it
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        drive(v.addr, v.we, v.rd, v.wdata, v.in_vld, v.in_data, v.out_rdy);
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        chk({tag, " io_din"}, bus.io_din, e.exp_din);
        cyc();
        chk({tag, " out_vld"}, {31'h0, out_vld}, {31'h0, e.exp_vld});
        chk({tag, " out_data"}, out_data, e.exp_odata);
        chk({tag, " led"}, {16'h0, led}, {16'h0, e.exp_led});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        drive(8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_vld", {31'h0, out_vld}, 32'h0);
        chk("reset out_data", out_data, 32'h0);
        chk("reset led", {16'h0, led}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc();

        // FIFO ordering and empty read
        add(8'h00,1'b0,1'b0,32'h0,1'b1,32'hA,1'b0, 32'h0,1'b0,32'h0,16'h0);
        add(8'h00,1'b0,1'b0,32'h0,1'b1,32'hB,1'b0, 32'h0,1'b0,32'h0,16'h0);
        add(8'h00,1'b0,1'b0,32'h0,1'b1,32'hC,1'b0, 32'h0,1'b0,32'h0,16'h0);
        add(8'h04,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'h0000_0301,1'b0,32'h0,16'h0);
        add(8'h08,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'hA,1'b0,32'h0,16'h0);
        add(8'h08,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'hB,1'b0,32'h0,16'h0);
        add(8'h08,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'hC,1'b0,32'h0,16'h0);
        add(8'h08,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'h0,1'b0,32'h0,16'h0);
        add(8'h04,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'h0,1'b0,32'h0,16'h0);
        // Overflow, full push+pop, sticky set-wins, flush
        for (int i = 0; i < 9; i++) begin
            add(8'h00,1'b0,1'b0,32'h0,1'b1,32'h100 + 32'(i),1'b0, 32'h0,1'b0,32'h0,16'h0);
        end
        add(8'h04,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'h0000_0803,1'b0,32'h0,16'h0);
        add(8'h14,1'b1,1'b0,32'h1,1'b0,32'h0,1'b0, 32'h0,1'b0,32'h0,16'h0);
        add(8'h04,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'h0000_0801,1'b0,32'h0,16'h0);
        add(8'h08,1'b0,1'b1,32'h0,1'b1,32'h200,1'b0, 32'h100,1'b0,32'h0,16'h0);
        add(8'h04,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'h0000_0801,1'b0,32'h0,16'h0);
        add(8'h08,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'h101,1'b0,32'h0,16'h0);
        add(8'h00,1'b0,1'b0,32'h0,1'b1,32'h300,1'b0, 32'h0,1'b0,32'h0,16'h0);
        add(8'h14,1'b1,1'b0,32'h1,1'b1,32'h301,1'b0, 32'h0,1'b0,32'h0,16'h0);
        add(8'h04,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'h0000_0803,1'b0,32'h0,16'h0);
        add(8'h14,1'b1,1'b0,32'h5,1'b0,32'h0,1'b0, 32'h0,1'b0,32'h0,16'h0);
        add(8'h04,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'h0,1'b0,32'h0,16'h0);
        add(8'h00,1'b0,1'b0,32'h0,1'b1,32'h400,1'b0, 32'h0,1'b0,32'h0,16'h0);
        add(8'h14,1'b1,1'b0,32'h4,1'b1,32'h401,1'b0, 32'h0,1'b0,32'h0,16'h0);
        add(8'h04,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'h0,1'b0,32'h0,16'h0);
        add(8'h08,1'b1,1'b0,32'hDEAD,1'b0,32'h0,1'b0, 32'h0,1'b0,32'h0,16'h0);
        add(8'h04,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'h0,1'b0,32'h0,16'h0);
        // Output slot handshake
        add(8'h10,1'b1,1'b0,32'h1234,1'b0,32'h0,1'b0, 32'h0,1'b1,32'h1234,16'h0);
        add(8'h10,1'b1,1'b0,32'h5678,1'b0,32'h0,1'b0, 32'h0,1'b1,32'h1234,16'h0);
        add(8'h0C,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'h2,1'b1,32'h1234,16'h0);
        add(8'h10,1'b1,1'b0,32'h9ABC,1'b0,32'h0,1'b1, 32'h0,1'b1,32'h9ABC,16'h0);
        add(8'h00,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1, 32'h0,1'b0,32'h9ABC,16'h0);
        add(8'h0C,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'h3,1'b0,32'h9ABC,16'h0);
        add(8'h14,1'b1,1'b0,32'h2,1'b0,32'h0,1'b0, 32'h0,1'b0,32'h9ABC,16'h0);
        add(8'h0C,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'h1,1'b0,32'h9ABC,16'h0);
        // LED and ignored/unmapped accesses
        add(8'h00,1'b1,1'b0,32'hFFFF_00A5,1'b0,32'h0,1'b0, 32'h0,1'b0,32'h9ABC,16'h00A5);
        add(8'h00,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'hA5,1'b0,32'h9ABC,16'h00A5);
        add(8'h04,1'b1,1'b0,32'hFFFF_FFFF,1'b0,32'h0,1'b0, 32'h0,1'b0,32'h9ABC,16'h00A5);
        add(8'h04,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'h0,1'b0,32'h9ABC,16'h00A5);
        add(8'h0C,1'b1,1'b0,32'hFFFF_FFFF,1'b0,32'h0,1'b0, 32'h0,1'b0,32'h9ABC,16'h00A5);
        add(8'h0C,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'h1,1'b0,32'h9ABC,16'h00A5);
        add(8'h18,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'h0,1'b0,32'h9ABC,16'h00A5);
        add(8'h20,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'h0,1'b0,32'h9ABC,16'h00A5);
        add(8'h00,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0, 32'h0,1'b0,32'h9ABC,16'h00A5);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

`ifdef IO_RESPONDER_IRQ_EN
        // Interrupt: one-cycle latency on set and on clear
        drive(8'h18, 1'b1, 1'b0, 32'h1, 1'b0, 32'h0, 1'b0);
        cyc();
        drive(8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 32'h42, 1'b0);
        cyc();
        chk("irq after push edge", {31'h0, irq}, 32'h0);
        drive(8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc();
        chk("irq one cycle later", {31'h0, irq}, 32'h1);
        drive(8'h08, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("irq pop data", bus.io_din, 32'h42);
        cyc();
        chk("irq at pop edge", {31'h0, irq}, 32'h1);
        drive(8'h18, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("irq mask readback", bus.io_din, 32'h1);
        cyc();
        chk("irq cleared", {31'h0, irq}, 32'h0);
`endif

        // Reset asserted mid-handshake with a word in the FIFO
        apply('{8'h10,1'b1,1'b0,32'h55,1'b1,32'h77,1'b0, 32'h0,1'b1,32'h55,16'h00A5}, "pre-reset");
        drive(8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("async reset out_vld", {31'h0, out_vld}, 32'h0);
        chk("async reset out_data", out_data, 32'h0);
        chk("async reset led", {16'h0, led}, 32'h0);
        drive(8'h04, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("in reset IN_STAT", bus.io_din, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc();
        apply('{8'h04,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'h0,1'b0,32'h0,16'h0}, "post-reset IN_STAT");
        apply('{8'h0C,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'h1,1'b0,32'h0,16'h0}, "post-reset OUT_STAT");
        apply('{8'h08,1'b0,1'b1,32'h0,1'b0,32'h0,1'b0, 32'h0,1'b0,32'h0,16'h0}, "post-reset IN_DATA");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
